// File: rtl/jtsdram_bank_arb.sv
// SDRAM access arbiter: refresh > programmer > round-robin bank readers.
// One grant open at a time, released by ack or by a sticky watchdog timeout.
module jtsdram_bank_arb #(
   parameter int TOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ref_req,
   input  logic       prog_req,
   input  logic [3:0] ba_req,
   input  logic       ack,
   output logic       ref_gnt,
   output logic       prog_gnt,
   output logic [3:0] ba_gnt,
   output logic [2:0] owner,
   output logic       busy,
   output logic       timeout
);

   localparam int CW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
   localparam logic [CW-1:0] LIMIT   = CW'(TOUT - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TOUT);

   localparam logic [2:0] OWN_NONE = 3'd0;
   localparam logic [2:0] OWN_PROG = 3'd5;
   localparam logic [2:0] OWN_REF  = 3'd6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ref_gnt_q, ref_gnt_d;
   logic            prog_gnt_q, prog_gnt_d;
   logic [3:0]      ba_gnt_q, ba_gnt_d;
   logic [2:0]      owner_q, owner_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic [1:0]      rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Round-robin search: rotate requests so rr_q sits at bit 0, then take the lowest set bit.
   logic [7:0]      ba_dbl;
   logic [3:0]      ba_rot;
   logic [1:0]      rr_off;
   logic [1:0]      rr_pick;
   logic            ba_any;

   always_comb begin
      ba_dbl = {ba_req, ba_req};
      ba_rot = ba_dbl[rr_q +: 4];
      ba_any = |ba_req;
      rr_off = 2'd0;
      if (ba_rot[0])      rr_off = 2'd0;
      else if (ba_rot[1]) rr_off = 2'd1;
      else if (ba_rot[2]) rr_off = 2'd2;
      else if (ba_rot[3]) rr_off = 2'd3;
      rr_pick = rr_q + rr_off;
   end

   // Bank index of the current holder (owner 1..4 maps to bank 0..3).
   logic [1:0]      held_bank;
   logic            held_is_bank;

   assign held_bank    = owner_q[1:0] - 2'd1;
   assign held_is_bank = (owner_q != OWN_NONE) && (owner_q <= 3'd4);

   always_comb begin
      state_d    = state_q;
      ref_gnt_d  = ref_gnt_q;
      prog_gnt_d = prog_gnt_q;
      ba_gnt_d   = ba_gnt_q;
      owner_d    = owner_q;
      busy_d     = busy_q;
      timeout_d  = timeout_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (ref_req) begin
               state_d   = GRANT;
               ref_gnt_d = 1'b1;
               owner_d   = OWN_REF;
               busy_d    = 1'b1;
               cnt_d     = '0;
            end else if (prog_req) begin
               state_d    = GRANT;
               prog_gnt_d = 1'b1;
               owner_d    = OWN_PROG;
               busy_d     = 1'b1;
               cnt_d      = '0;
            end else if (ba_any) begin
               state_d  = GRANT;
               ba_gnt_d = 4'b0001 << rr_pick;
               owner_d  = {1'b0, rr_pick} + 3'd1;
               busy_d   = 1'b1;
               cnt_d    = '0;
            end
         end

         GRANT: begin
            if (ack || cnt_q == LIMIT) begin
               state_d    = GAP;
               ref_gnt_d  = 1'b0;
               prog_gnt_d = 1'b0;
               ba_gnt_d   = 4'b0000;
               owner_d    = OWN_NONE;
               cnt_d      = '0;
               // ack takes precedence over a simultaneous watchdog expiry
               if (ack) begin
                  if (held_is_bank) begin
                     rr_d = held_bank + 2'd1;
                  end
               end else begin
                  timeout_d = 1'b1;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         GAP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d    = IDLE;
            ref_gnt_d  = 1'b0;
            prog_gnt_d = 1'b0;
            ba_gnt_d   = 4'b0000;
            owner_d    = OWN_NONE;
            busy_d     = 1'b0;
            cnt_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ref_gnt_q  <= 1'b0;
         prog_gnt_q <= 1'b0;
         ba_gnt_q   <= 4'b0000;
         owner_q    <= OWN_NONE;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         rr_q       <= 2'd0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ref_gnt_q  <= ref_gnt_d;
         prog_gnt_q <= prog_gnt_d;
         ba_gnt_q   <= ba_gnt_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ref_gnt  = ref_gnt_q;
   assign prog_gnt = prog_gnt_q;
   assign ba_gnt   = ba_gnt_q;
   assign owner    = owner_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: doc/jtsdram_bank_arb.md
JTSDRAM_BANK_ARB -- requirements
Module: jtsdram_bank_arb

Interface
REQ-001 Parameter TOUT, default 255: watchdog limit, in clock cycles, that a grant may stay open without ack.
REQ-002 The block SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 The block SHALL have port ref_req, input, 1: level refresh request.
REQ-005 The block SHALL have port prog_req, input, 1: level request from the SDRAM programmer.
REQ-006 The block SHALL have port ba_req, input, 4: level requests from the bank 0-3 readers; bit n is bank n.
REQ-007 The block SHALL have port ack, input, 1: one-cycle pulse from the SDRAM controller when the granted access completes.
REQ-008 The block SHALL have port ref_gnt, output, 1: refresh grant.
REQ-009 The block SHALL have port prog_gnt, output, 1: programmer grant.
REQ-010 The block SHALL have port ba_gnt, output, 4: bank reader grants.
REQ-011 The block SHALL have port owner, output, 3: encoded grant holder; 0 = none, 1-4 = bank 0-3, 5 = prog, 6 = ref; 7 is never driven.
REQ-012 The block SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port timeout, output, 1: sticky watchdog error flag.

Function
REQ-014 The block SHALL implement an FSM with three states: IDLE, GRANT and GAP.
REQ-015 All outputs SHALL be registered.
REQ-016 At most one of ref_gnt, prog_gnt and ba_gnt[3:0] SHALL be high in any cycle.
REQ-017 In IDLE, when any request is sampled high at edge N, the FSM SHALL enter GRANT at edge N, and the grant and owner SHALL be visible from cycle N+1 (latency 1).
REQ-018 Priority SHALL be fixed: ref_req first, then prog_req, then ba_req.
REQ-019 Bank requests SHALL be served round-robin from a 2-bit pointer rr_ptr: the first set bit searching rr_ptr, rr_ptr+1, ... modulo 4 wins.
REQ-020 In GRANT, the grant and owner SHALL hold regardless of the request lines; withdrawing a request SHALL NOT release the grant.
REQ-021 In GRANT, a watchdog counter cleared on entry SHALL increment every cycle.
REQ-022 In GRANT with ack high, the FSM SHALL drop all grants, set owner=0, enter GAP and clear the counter.
REQ-023 On an ack that completes a bank grant, rr_ptr SHALL become the granted bank index +1, wrapping 3 -> 0.
REQ-024 In GRANT, when the counter equals TOUT-1 and ack is low, the FSM SHALL drop all grants, set timeout=1, enter GAP, and leave rr_ptr unchanged.
REQ-025 When ack and the watchdog limit coincide, ack SHALL win: timeout stays unchanged and rr_ptr is updated as in REQ-023.
REQ-026 GAP SHALL last one cycle with all grants low, then return to IDLE; consecutive grants are therefore separated by at least 2 cycles with all grants low.
REQ-027 ack in IDLE or GAP SHALL be ignored.
REQ-028 The timeout flag SHALL clear only on reset.
REQ-029 The watchdog counter width SHALL be clog2(TOUT+1) and SHALL never wrap.
REQ-030 A request that stays high SHALL be re-granted after GAP/IDLE if it still wins arbitration.

Reset
REQ-031 While rst_n is low, the block SHALL asynchronously force: state=IDLE, all grants=0, owner=0, busy=0, timeout=0, rr_ptr=0, counter=0.
REQ-032 An rst_n assertion during GRANT SHALL drop the grant immediately without waiting for a clock edge.
REQ-033 After rst_n rises, the first arbitration SHALL occur at the first rising edge at which rst_n is high.

Verification
REQ-034 Bench scenario: ba_req=4'b1111 held, ack pulsed 3 cycles after each grant -> owner sequence 1,2,3,4,1; ba_gnt is one-hot each time.
REQ-035 Bench scenario: ref_req, prog_req and ba_req=4'b0001 rise in the same cycle -> ref_gnt first; then prog_gnt; then ba_gnt[0], each after its ack.
REQ-036 Bench scenario: prog_req granted and ack never arrives, with TOUT=8 -> prog_gnt high exactly 8 cycles; timeout=1 and stays 1 through later grants.
REQ-037 Bench scenario: ack arrives in the same cycle the watchdog expires on bank 2 -> timeout=0 and the next bank grant search starts at bank 3.
REQ-038 Bench scenario: rst_n pulsed low mid-GRANT on bank 1 -> grants, owner and busy go to 0 before the next edge; after release, ba_req=4'b0011 -> bank 0 is granted first (rr_ptr=0).
REQ-039 Bench scenario: ack pulsed in IDLE with no requests -> no state change, busy=0; ba_req[1] dropped mid-GRANT -> ba_gnt[1] holds until ack.
